// File: rtl/cpu_controller.sv
// VeriRISC sequencer: eight-phase instruction cycle with sticky halt.
// Strobes are a Moore decode of the phase, qualified by opcode and zero.
package cpu_pkg;
  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;
endpackage

module cpu_controller
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  opcode_t    opcode,
  input  logic       zero,
  output logic       sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       load_ir,
  output logic       load_ac,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  if (NUM_PHASES != 8) begin : g_bad_phases
    $error("cpu_controller: NUM_PHASES must be 8");
  end

  phase_t phase_q;
  logic   halted_q;
  logic   aluop;

  assign aluop = (opcode == ADD) || (opcode == AND) ||
                 (opcode == XOR) || (opcode == LDA);
  assign phase = phase_q;

  // Phase counter; HLT leaving OP_ADDR parks it at OP_FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else if (!halted_q) begin
      if (phase_q == OP_ADDR && opcode == HLT) begin
        phase_q  <= OP_FETCH;
        halted_q <= 1'b1;
      end else begin
        phase_q <= phase_t'(phase_q + 3'd1);
      end
    end
  end

  // Strobe decode from phase, opcode and zero.
  always_comb begin
    sel     = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    load_ir = 1'b0;
    load_ac = 1'b0;
    inc_pc  = 1'b0;
    load_pc = 1'b0;
    data_e  = 1'b0;
    halt    = halted_q;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel    = 1'b1;
          mem_rd = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel     = 1'b1;
          mem_rd  = 1'b1;
          load_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
        end
        OP_FETCH: begin
          mem_rd = aluop;
        end
        ALU_OP: begin
          mem_rd  = aluop;
          inc_pc  = (opcode == SKZ) && zero;
          load_pc = (opcode == JMP);
          data_e  = (opcode == STO);
        end
        STORE: begin
          mem_rd  = aluop;
          load_ac = aluop;
          inc_pc  = (opcode == JMP);
          load_pc = (opcode == JMP);
          mem_wr  = (opcode == STO);
          data_e  = (opcode == STO);
        end
        default: ;
      endcase
    end
  end

  a_rd_wr_excl: assert property (
    @(posedge clk) disable iff (rst) !(mem_rd && mem_wr));

  a_opcode_known: assert property (
    @(posedge clk) disable iff (rst) !$isunknown(opcode));

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed scenarios plus random opcode
// streams compared every cycle against a phase/halt reference model.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  opcode_t    opcode = ADD;
  logic       zero = 1'b0;
  logic       sel, mem_rd, mem_wr, load_ir, load_ac;
  logic       inc_pc, load_pc, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  int m_phase = 0;
  bit m_halt = 1'b0;

  cpu_controller #(.NUM_PHASES(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
    .sel(sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .load_ir(load_ir), .load_ac(load_ac), .inc_pc(inc_pc),
    .load_pc(load_pc), .data_e(data_e), .halt(halt),
    .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,wr,ir,ac,inc,ldpc,de,halt}
  function automatic logic [8:0] expect_out(int ph, bit h,
                                            int op, bit z);
    bit a, s, rd, wr, ir, ac, inc, lp, de;
    if (h) return 9'b000000001;
    a   = (op >= 2 && op <= 5);
    s   = ph < 4;
    rd  = (ph >= 1 && ph <= 3) || (ph >= 5 && a);
    ir  = (ph == 2 || ph == 3);
    ac  = a && ph == 7;
    wr  = op == 6 && ph == 7;
    inc = ph == 4 || (ph == 6 && op == 1 && z) ||
          (ph == 7 && op == 7);
    lp  = op == 7 && ph >= 6;
    de  = op == 6 && ph >= 6;
    return {s, rd, wr, ir, ac, inc, lp, de, 1'b0};
  endfunction

  // Reference model: instruction-cycle position and halted flag.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_halt  = 1'b0;
    end else if (!m_halt) begin
      if (m_phase == 4 && opcode == HLT) begin
        m_halt  = 1'b1;
        m_phase = 5;
      end else begin
        m_phase = (m_phase + 1) % 8;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst) begin
      e = expect_out(m_phase, m_halt, int'(opcode), zero);
      chk("phase",   int'(phase),   m_phase);
      chk("sel",     int'(sel),     int'(e[8]));
      chk("mem_rd",  int'(mem_rd),  int'(e[7]));
      chk("mem_wr",  int'(mem_wr),  int'(e[6]));
      chk("load_ir", int'(load_ir), int'(e[5]));
      chk("load_ac", int'(load_ac), int'(e[4]));
      chk("inc_pc",  int'(inc_pc),  int'(e[3]));
      chk("load_pc", int'(load_pc), int'(e[2]));
      chk("data_e",  int'(data_e),  int'(e[1]));
      chk("halt",    int'(halt),    int'(e[0]));
    end
  end

  function automatic int strobes();
    return int'({mem_rd, mem_wr, load_ir, load_ac,
                 inc_pc, load_pc, data_e});
  endfunction

  // Reset held across one edge; released 2ns after a rising edge.
  task automatic do_reset(opcode_t op, logic z);
    @(posedge clk);
    #2;
    rst = 1'b1;
    opcode = op;
    zero = z;
    #1;
    chk("rst_phase", int'(phase), 0);
    chk("rst_sel", int'(sel), 1);
    chk("rst_halt", int'(halt), 0);
    chk("rst_strobes", strobes(), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int hcnt;

    do_reset(ADD, 1'b0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("seq_phase", int'(phase), k % 8);
      chk("seq_mem_wr", int'(mem_wr), 0);
      if (k % 8 == 2) chk("seq_load_ir", int'(load_ir), 1);
      if (k % 8 == 4) chk("seq_inc_pc", int'(inc_pc), 1);
      if (k % 8 == 5) chk("seq_mem_rd", int'(mem_rd), 1);
      if (k % 8 == 7) chk("seq_load_ac", int'(load_ac), 1);
    end

    do_reset(STO, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 6) begin
        chk("sto_alu_de", int'(data_e), 1);
        chk("sto_alu_wr", int'(mem_wr), 0);
      end
      if (k == 7) begin
        chk("sto_st_wr", int'(mem_wr), 1);
        chk("sto_st_de", int'(data_e), 1);
        chk("sto_st_ac", int'(load_ac), 0);
        chk("sto_st_rd", int'(mem_rd), 0);
      end
    end

    for (int zz = 1; zz >= 0; zz--) begin
      do_reset(SKZ, zz[0]);
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (k == 4) chk("skz_opaddr_inc", int'(inc_pc), 1);
        if (k == 6) chk("skz_alu_inc", int'(inc_pc), zz);
      end
    end

    do_reset(JMP, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k >= 5) chk("jmp_mem_rd", int'(mem_rd), 0);
      if (k >= 6) chk("jmp_load_pc", int'(load_pc), 1);
      if (k == 7) chk("jmp_st_inc", int'(inc_pc), 1);
    end

    do_reset(HLT, 1'b0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k < 5) chk("hlt_pre", int'(halt), 0);
      if (k >= 5) begin
        chk("hlt_halt", int'(halt), 1);
        chk("hlt_phase", int'(phase), 5);
        chk("hlt_sel", int'(sel), 0);
        chk("hlt_strobes", strobes(), 0);
      end
      if (k == 10) begin
        @(posedge clk);
        #2;
        opcode = ADD;
        zero = 1'b1;
      end
    end
    do_reset(ADD, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hlt_resume_halt", int'(halt), 0);
      chk("hlt_resume_phase", int'(phase), k);
    end

    do_reset(XOR, 1'b0);
    for (int k = 0; k < 7; k++) @(negedge clk);
    chk("mid_pre_phase", int'(phase), 6);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_phase", int'(phase), 0);
    chk("mid_sel", int'(sel), 1);
    chk("mid_strobes", strobes(), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_restart0", int'(phase), 0);
    @(negedge clk);
    chk("mid_restart1", int'(phase), 1);

    hcnt = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      if (m_halt) hcnt++;
      else hcnt = 0;
      if (hcnt > 6 || $urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        hcnt = 0;
      end
      if ($urandom_range(0, 29) == 0) opcode = HLT;
      else opcode = opcode_t'($urandom_range(1, 7));
      zero = 1'($urandom_range(0, 1));
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
